// File: rtl/ctl_duck_flight_if.sv
`default_nettype none
// ============================================================================
// ctl_duck_flight_if : frame/shot strobes in, duck sprite position/flags out.
// Rev 1.0
// ============================================================================
interface ctl_duck_flight_if #(
  parameter int W = 10
);
  logic         new_frame;
  logic         shot_hit;
  logic [W-1:0] duck_x;
  logic [W-1:0] duck_y;
  logic         duck_show;
  logic         duck_flap;
  logic         duck_hit;
  logic         duck_escaped;

  modport master (
    output new_frame, shot_hit,
    input  duck_x, duck_y, duck_show, duck_flap, duck_hit, duck_escaped
  );

  modport slave (
    input  new_frame, shot_hit,
    output duck_x, duck_y, duck_show, duck_flap, duck_hit, duck_escaped
  );
endinterface
`default_nettype wire

// File: rtl/ctl_duck_flight.sv
`default_nettype none
// ============================================================================
// ctl_duck_flight : duck fly/hit/fall/escape/respawn sequencer, frame-paced.
// Option macro CTL_DUCK_RANDOM_SPAWN_EN: LFSR-chosen spawn x and direction.
// Rev 1.0
// ============================================================================
module ctl_duck_flight #(
  parameter int W              = 10,
  parameter int X_MAX          = 600,
  parameter int Y_MIN          = 0,
  parameter int Y_MAX          = 400,
  parameter int HOR_SPD        = 7,
  parameter int VER_SPD        = 3,
  parameter int FALL_SPD       = 5,
  parameter int ESC_FRAMES     = 180,
  parameter int HIT_FRAMES     = 20,
  parameter int RESPAWN_FRAMES = 60,
  parameter int FLAP_DIV       = 4
) (
  input  wire logic        clk,
  input  wire logic        rst,
  ctl_duck_flight_if.slave bus
);

  localparam int CNT_TOP = (ESC_FRAMES > HIT_FRAMES)
                         ? ((ESC_FRAMES > RESPAWN_FRAMES) ? ESC_FRAMES : RESPAWN_FRAMES)
                         : ((HIT_FRAMES > RESPAWN_FRAMES) ? HIT_FRAMES : RESPAWN_FRAMES);
  localparam int CW = $clog2(CNT_TOP + 1);
  localparam int FW = $clog2(FLAP_DIV + 1);

  localparam logic [W:0]   C_X_MAX  = (W+1)'(X_MAX);
  localparam logic [W:0]   C_Y_MAX  = (W+1)'(Y_MAX);
  localparam logic [W:0]   C_HOR    = (W+1)'(HOR_SPD);
  localparam logic [W:0]   C_VER    = (W+1)'(VER_SPD);
  localparam logic [W:0]   C_FALL   = (W+1)'(FALL_SPD);
  localparam logic [W:0]   C_Y_LO   = (W+1)'(Y_MIN + VER_SPD);
  localparam logic [W:0]   C_ESC_LO = (W+1)'(Y_MIN + 2 * VER_SPD);
  localparam logic [W-1:0] C_XMAX_W = W'(X_MAX);
  localparam logic [W-1:0] C_YMIN_W = W'(Y_MIN);
  localparam logic [W-1:0] C_YMAX_W = W'(Y_MAX);

  typedef enum logic [2:0] {
    S_HIDDEN = 3'd0,
    S_FLY    = 3'd1,
    S_HIT    = 3'd2,
    S_FALL   = 3'd3,
    S_ESCAPE = 3'd4
  } state_t;

  state_t         state_q, state_d;
  logic [CW-1:0]  cnt_q, cnt_d, cnt_inc;
  logic [FW-1:0]  flap_cnt_q, flap_cnt_d, flap_cnt_inc;
  logic [W-1:0]   x_q, x_d, y_q, y_d;
  logic           dir_x_q, dir_x_d, dir_y_q, dir_y_d;
  logic           show_q, show_d, flap_q, flap_d, hit_q, hit_d, escaped_q, escaped_d;
  logic           wing_adv;
  logic [W:0]     x_ext, y_ext, x_up, x_dn, y_up, y_dn, y_fall;
  logic [W-1:0]   spawn_x;
  logic           spawn_dir;

  // Motion arithmetic is one bit wider than the coordinates so bounds tests never wrap.
  assign x_ext        = {1'b0, x_q};
  assign y_ext        = {1'b0, y_q};
  assign x_up         = x_ext + C_HOR;
  assign x_dn         = x_ext - C_HOR;
  assign y_up         = y_ext + C_VER;
  assign y_dn         = y_ext - C_VER;
  assign y_fall       = y_ext + C_FALL;
  assign cnt_inc      = cnt_q + CW'(1);
  assign flap_cnt_inc = flap_cnt_q + FW'(1);

`ifdef CTL_DUCK_RANDOM_SPAWN_EN
  localparam logic [16:0] C_SPAWN_MOD = 17'(X_MAX + 1);
  logic [15:0] lfsr_q, lfsr_d;
  logic [16:0] spawn_mod;

  assign lfsr_d    = {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
  assign spawn_mod = {1'b0, lfsr_q} % C_SPAWN_MOD;
  assign spawn_x   = W'(spawn_mod);
  assign spawn_dir = lfsr_q[0];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) lfsr_q <= 16'hACE1;
    else     lfsr_q <= lfsr_d;
  end
`else
  assign spawn_x   = '0;
  assign spawn_dir = 1'b1;
`endif

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    flap_cnt_d = flap_cnt_q;
    x_d        = x_q;
    y_d        = y_q;
    dir_x_d    = dir_x_q;
    dir_y_d    = dir_y_q;
    flap_d     = flap_q;
    escaped_d  = 1'b0;
    wing_adv   = 1'b0;

    case (state_q)
      S_FLY: begin
        // A shot wins over a coincident frame: freeze where the duck was.
        if (bus.shot_hit) begin
          state_d = S_HIT;
          cnt_d   = '0;
        end else if (bus.new_frame) begin
          wing_adv = 1'b1;
          if (dir_x_q) begin
            if (x_up > C_X_MAX) begin x_d = C_XMAX_W; dir_x_d = 1'b0; end
            else                      x_d = x_up[W-1:0];
          end else begin
            if (x_ext < C_HOR)  begin x_d = '0;       dir_x_d = 1'b1; end
            else                      x_d = x_dn[W-1:0];
          end
          if (dir_y_q) begin
            if (y_up > C_Y_MAX)  begin y_d = C_YMAX_W; dir_y_d = 1'b0; end
            else                       y_d = y_up[W-1:0];
          end else begin
            if (y_ext < C_Y_LO)  begin y_d = C_YMIN_W; dir_y_d = 1'b1; end
            else                       y_d = y_dn[W-1:0];
          end
          if (cnt_inc == CW'(ESC_FRAMES)) begin state_d = S_ESCAPE; cnt_d = '0; end
          else                                  cnt_d = cnt_inc;
        end
      end
      S_HIT: begin
        if (bus.new_frame) begin
          if (cnt_inc == CW'(HIT_FRAMES)) begin state_d = S_FALL; cnt_d = '0; end
          else                                  cnt_d = cnt_inc;
        end
      end
      S_FALL: begin
        if (bus.new_frame) begin
          if (y_fall >= C_Y_MAX) begin
            y_d     = C_YMAX_W;
            state_d = S_HIDDEN;
            cnt_d   = '0;
          end else begin
            y_d = y_fall[W-1:0];
          end
        end
      end
      S_ESCAPE: begin
        if (bus.new_frame) begin
          wing_adv = 1'b1;
          if (y_ext < C_ESC_LO) begin
            y_d       = (y_ext < C_Y_LO) ? C_YMIN_W : y_dn[W-1:0];
            escaped_d = 1'b1;
            state_d   = S_HIDDEN;
            cnt_d     = '0;
          end else begin
            y_d = y_dn[W-1:0];
          end
        end
      end
      S_HIDDEN: begin
        if (bus.new_frame) begin
          if (cnt_inc == CW'(RESPAWN_FRAMES)) begin
            state_d = S_FLY;
            cnt_d   = '0;
            x_d     = spawn_x;
            y_d     = C_YMAX_W;
            dir_x_d = spawn_dir;
            dir_y_d = 1'b0;
          end else begin
            cnt_d = cnt_inc;
          end
        end
      end
      default: state_d = S_HIDDEN;
    endcase

    if (wing_adv) begin
      if (flap_cnt_inc == FW'(FLAP_DIV)) begin flap_cnt_d = '0; flap_d = ~flap_q; end
      else                                       flap_cnt_d = flap_cnt_inc;
    end
    // Wings only beat while airborne under the duck's own power.
    if (state_d != S_FLY && state_d != S_ESCAPE) begin
      flap_d     = 1'b0;
      flap_cnt_d = '0;
    end

    show_d = (state_d != S_HIDDEN);
    hit_d  = (state_d == S_HIT) || (state_d == S_FALL);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= S_HIDDEN;
      cnt_q      <= '0;
      flap_cnt_q <= '0;
      x_q        <= '0;
      y_q        <= C_YMAX_W;
      dir_x_q    <= 1'b1;
      dir_y_q    <= 1'b0;
      show_q     <= 1'b0;
      flap_q     <= 1'b0;
      hit_q      <= 1'b0;
      escaped_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      flap_cnt_q <= flap_cnt_d;
      x_q        <= x_d;
      y_q        <= y_d;
      dir_x_q    <= dir_x_d;
      dir_y_q    <= dir_y_d;
      show_q     <= show_d;
      flap_q     <= flap_d;
      hit_q      <= hit_d;
      escaped_q  <= escaped_d;
    end
  end

  assign bus.duck_x       = x_q;
  assign bus.duck_y       = y_q;
  assign bus.duck_show    = show_q;
  assign bus.duck_flap    = flap_q;
  assign bus.duck_hit     = hit_q;
  assign bus.duck_escaped = escaped_q;

endmodule
`default_nettype wire

// File: tb/tb_ctl_duck_flight.sv
`default_nettype none
// ============================================================================
// tb_ctl_duck_flight : random frame/shot stimulus against a per-cycle flight model.
// Rev 1.0
// ============================================================================
module tb_ctl_duck_flight;
  localparam int W = 10;
  localparam int X_MAX = 600, Y_MIN = 0, Y_MAX = 400;
  localparam int HOR_SPD = 7, VER_SPD = 3, FALL_SPD = 5;
  localparam int ESC_FRAMES = 180, HIT_FRAMES = 20, RESPAWN_FRAMES = 60, FLAP_DIV = 4;
  localparam int M_HIDDEN = 0, M_FLY = 1, M_HIT = 2, M_FALL = 3, M_ESCAPE = 4;
  localparam logic [2*W+3:0] RESET_VEC = {W'(0), W'(Y_MAX), 4'b0000};

  logic clk;
  logic rst;
  int   passed = 0;
  int   total  = 0;

  // behavioural duck: mode, position, direction, frames spent in mode, airborne frames
  int m_mode, m_x, m_y, m_dx, m_dy, m_cnt, m_fl;
  bit m_esc;

  ctl_duck_flight_if #(.W(W)) bus ();

  ctl_duck_flight #(.W(W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [2*W+3:0] dvec;
  assign dvec = {bus.duck_x, bus.duck_y, bus.duck_show, bus.duck_flap, bus.duck_hit, bus.duck_escaped};

  function automatic logic [2*W+3:0] mvec();
    logic s, f, h;
    s = (m_mode != M_HIDDEN);
    h = (m_mode == M_HIT) || (m_mode == M_FALL);
    f = ((m_mode == M_FLY) || (m_mode == M_ESCAPE)) && (((m_fl / FLAP_DIV) % 2) == 1);
    return {W'(m_x), W'(m_y), s, f, h, m_esc};
  endfunction

  function automatic void model_reset();
    m_mode = M_HIDDEN; m_x = 0; m_y = Y_MAX; m_dx = 1; m_dy = -1;
    m_cnt = 0; m_fl = 0; m_esc = 1'b0;
  endfunction

  function automatic void model_step(input bit nf, input bit sh);
    m_esc = 1'b0;
    case (m_mode)
      M_FLY: begin
        if (sh) begin
          m_mode = M_HIT; m_cnt = 0;
        end else if (nf) begin
          m_x = m_x + m_dx * HOR_SPD;
          if (m_x > X_MAX) begin m_x = X_MAX; m_dx = -1; end
          else if (m_x < 0) begin m_x = 0; m_dx = 1; end
          m_y = m_y + m_dy * VER_SPD;
          if (m_y > Y_MAX) begin m_y = Y_MAX; m_dy = -1; end
          else if (m_y < Y_MIN) begin m_y = Y_MIN; m_dy = 1; end
          m_fl++;
          m_cnt++;
          if (m_cnt == ESC_FRAMES) begin m_mode = M_ESCAPE; m_cnt = 0; end
        end
      end
      M_HIT: if (nf) begin
        m_cnt++;
        if (m_cnt == HIT_FRAMES) begin m_mode = M_FALL; m_cnt = 0; end
      end
      M_FALL: if (nf) begin
        m_y = m_y + FALL_SPD;
        if (m_y >= Y_MAX) begin m_y = Y_MAX; m_mode = M_HIDDEN; m_cnt = 0; end
      end
      M_ESCAPE: if (nf) begin
        m_fl++;
        m_y = m_y - VER_SPD;
        if (m_y < Y_MIN + VER_SPD) begin
          if (m_y < Y_MIN) m_y = Y_MIN;
          m_esc = 1'b1; m_mode = M_HIDDEN; m_cnt = 0;
        end
      end
      default: if (nf) begin
        m_cnt++;
        if (m_cnt == RESPAWN_FRAMES) begin
          m_mode = M_FLY; m_cnt = 0; m_fl = 0;
          m_x = 0; m_y = Y_MAX; m_dx = 1; m_dy = -1;
        end
      end
    endcase
  endfunction

  task automatic cyc(input bit nf, input bit sh);
    @(negedge clk);
    bus.new_frame = nf;
    bus.shot_hit  = sh;
    @(posedge clk);
    model_step(nf, sh);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus.new_frame = 1'b0;
    bus.shot_hit  = 1'b0;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    total++;
    if (dvec !== RESET_VEC) $display("FAIL reset_state: dut=%h expected=%h", dvec, RESET_VEC);
    else passed++;
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_spawn();
    for (int i = 0; i < RESPAWN_FRAMES; i++) begin
      cyc(1'b1, 1'b0);
      total++;
      if (dvec !== mvec()) $display("FAIL spawn_wait[%0d]: dut=%h model=%h", i, dvec, mvec());
      else passed++;
    end
    total++;
    if ({bus.duck_show, bus.duck_x, bus.duck_y} !== {1'b1, W'(0), W'(400)})
      $display("FAIL spawn_point: show=%b x=%0d y=%0d expected 1/0/400", bus.duck_show, bus.duck_x, bus.duck_y);
    else passed++;
    cyc(1'b1, 1'b0);
    total++;
    if ({bus.duck_x, bus.duck_y} !== {W'(7), W'(397)})
      $display("FAIL first_move: x=%0d y=%0d expected 7/397", bus.duck_x, bus.duck_y);
    else passed++;
  endtask

  task automatic test_bounce();
    int n = 0;
    int errs = 0;
    while (!(m_x == 595 && m_dx == 1 && m_mode == M_FLY) && n < 400) begin
      cyc(($urandom_range(0, 2) != 0), 1'b0);
      n++;
      total++;
      if (dvec !== mvec()) begin
        errs++;
        if (errs < 5) $display("FAIL bounce_approach: dut=%h model=%h", dvec, mvec());
      end else passed++;
    end
    total++;
    if (n >= 400) $display("FAIL bounce_timeout: model x=%0d expected 595", m_x);
    else passed++;
    cyc(1'b1, 1'b0);
    total++;
    if (bus.duck_x !== W'(600)) $display("FAIL bounce_clamp: x=%0d expected 600", bus.duck_x);
    else passed++;
    cyc(1'b1, 1'b0);
    total++;
    if (bus.duck_x !== W'(593)) $display("FAIL bounce_reverse: x=%0d expected 593", bus.duck_x);
    else passed++;
  endtask

  task automatic test_hit_fall();
    int n = 0;
    int errs = 0;
    int hx = m_x;
    int hy = m_y;
    cyc(1'b1, 1'b1);
    total++;
    if ({bus.duck_x, bus.duck_y, bus.duck_hit} !== {W'(hx), W'(hy), 1'b1})
      $display("FAIL hit_freeze: x=%0d y=%0d hit=%b expected %0d/%0d/1", bus.duck_x, bus.duck_y, bus.duck_hit, hx, hy);
    else passed++;
    // shots sprinkled through HIT and FALL must change nothing
    while (m_mode != M_HIDDEN && n < 600) begin
      cyc(($urandom_range(0, 1) == 1), ($urandom_range(0, 3) == 0));
      n++;
      total++;
      if (dvec !== mvec()) begin
        errs++;
        if (errs < 5) $display("FAIL hit_fall_seq: dut=%h model=%h", dvec, mvec());
      end else passed++;
    end
    total++;
    if ({bus.duck_y, bus.duck_show} !== {W'(400), 1'b0})
      $display("FAIL fall_landing: y=%0d show=%b expected 400/0", bus.duck_y, bus.duck_show);
    else passed++;
  endtask

  task automatic test_ignored_shot();
    for (int i = 0; i < 12; i++) begin
      cyc(i[0], 1'b1);
      total++;
      if (dvec !== mvec()) $display("FAIL shot_in_hidden[%0d]: dut=%h model=%h", i, dvec, mvec());
      else passed++;
    end
  endtask

  task automatic test_escape();
    int n = 0;
    int pulses = 0;
    int errs = 0;
    bit seen = 1'b0;
    while (!(seen && m_mode == M_HIDDEN) && n < 3000) begin
      cyc(($urandom_range(0, 3) != 0), 1'b0);
      n++;
      if (m_mode == M_ESCAPE) seen = 1'b1;
      if (bus.duck_escaped === 1'b1) pulses++;
      total++;
      if (dvec !== mvec()) begin
        errs++;
        if (errs < 5) $display("FAIL escape_seq: dut=%h model=%h", dvec, mvec());
      end else passed++;
    end
    for (int i = 0; i < 3; i++) begin
      cyc(1'b0, 1'b0);
      if (bus.duck_escaped === 1'b1) pulses++;
    end
    total++;
    if (pulses != 1) $display("FAIL escape_pulse: pulses=%0d expected 1", pulses);
    else passed++;
  endtask

  task automatic test_async_reset();
    int n = 0;
    while (!(m_mode == M_FALL && m_y < Y_MAX - 3 * FALL_SPD) && n < 2000) begin
      cyc(1'b1, (m_mode == M_FLY) && (m_cnt > 5));
      n++;
    end
    total++;
    if (n >= 2000) $display("FAIL reach_fall: model mode=%0d expected FALL", m_mode);
    else passed++;
    #2 rst = 1'b1;
    #1;
    total++;
    if (dvec !== RESET_VEC) $display("FAIL async_reset: dut=%h expected=%h", dvec, RESET_VEC);
    else passed++;
    model_reset();
    repeat (2) @(posedge clk);
    #2 rst = 1'b0;
    for (int i = 0; i < RESPAWN_FRAMES - 1; i++) cyc(1'b1, 1'b0);
    total++;
    if (dvec !== mvec() || bus.duck_show !== 1'b0)
      $display("FAIL respawn_early: dut=%h model=%h", dvec, mvec());
    else passed++;
    cyc(1'b1, 1'b0);
    total++;
    if (bus.duck_show !== 1'b1 || dvec !== mvec())
      $display("FAIL respawn_after_reset: dut=%h model=%h", dvec, mvec());
    else passed++;
  endtask

  task automatic test_random();
    int errs = 0;
    for (int i = 0; i < 4000; i++) begin
      cyc(($urandom_range(0, 1) == 1), ($urandom_range(0, 149) == 0));
      total++;
      if (dvec !== mvec()) begin
        errs++;
        if (errs < 5) $display("FAIL random[%0d]: dut=%h model=%h", i, dvec, mvec());
      end else passed++;
    end
  endtask

  initial begin
    test_reset();
    test_spawn();
    test_bounce();
    test_hit_fall();
    test_ignored_shot();
    test_escape();
    test_async_reset();
    test_random();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/ctl_duck_flight.md
CTL_DUCK_FLIGHT -- requirements
Module: ctl_duck_flight

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-high reset, with ports named clk and rst.
REQ-002 The block SHALL provide parameter W, default 10: coordinate width in bits.
REQ-003 The block SHALL provide parameter X_MAX, default 600: rightmost legal duck_x.
REQ-004 The block SHALL provide parameter Y_MIN, default 0, and parameter Y_MAX, default 400: vertical flight band limits.
REQ-005 The block SHALL provide parameters HOR_SPD=7, VER_SPD=3, FALL_SPD=5: pixels moved per frame, each ≥1.
REQ-006 The block SHALL provide parameters ESC_FRAMES=180, HIT_FRAMES=20, RESPAWN_FRAMES=60 and FLAP_DIV=4.
REQ-007 Port clk: input, 1 bit, system clock.
REQ-008 Port rst: input, 1 bit, asynchronous active-high reset.
REQ-009 Port new_frame: input, 1 bit, one-cycle pulse per video frame.
REQ-010 Port shot_hit: input, 1 bit, one-cycle pulse meaning a shot landed on the duck.
REQ-011 Ports duck_x and duck_y: output, W bits each, duck top-left position.
REQ-012 Ports duck_show, duck_flap, duck_hit, duck_escaped: output, 1 bit each. duck_show = visible; duck_flap = wing frame select; duck_hit = hit or falling sprite; duck_escaped = one-cycle pulse when the duck leaves uncaught.

Function
REQ-013 The block SHALL implement the states FLY, HIT, FALL, ESCAPE and HIDDEN.
REQ-014 All position updates, frame counters and state advances SHALL occur only on cycles where new_frame=1. The exception is the shot_hit transition, which SHALL register on the following edge.
REQ-015 FLY motion: on each new_frame, x SHALL move ±HOR_SPD and y SHALL move ±VER_SPD according to the direction bits dir_x and dir_y.
REQ-016 FLY bounce: if the next x would exceed X_MAX or go below 0, x SHALL clamp to that bound and dir_x SHALL invert in the same update. y SHALL behave the same way against Y_MIN and Y_MAX. All arithmetic SHALL be done in W+1 bits so that no wrap is possible.
REQ-017 In FLY, shot_hit=1 SHALL move the state to HIT and freeze the position. shot_hit coinciding with new_frame SHALL take priority: no movement that frame.
REQ-018 In FLY, after ESC_FRAMES frames without a hit, the state SHALL move to ESCAPE.
REQ-019 HIT: the position SHALL be held for HIT_FRAMES frames, and the state SHALL then move to FALL.
REQ-020 FALL: y SHALL increase by FALL_SPD per frame. When the next y is ≥ Y_MAX, y SHALL clamp to Y_MAX and the state SHALL move to HIDDEN.
REQ-021 ESCAPE: y SHALL decrease by VER_SPD per frame. When the next y is < Y_MIN + VER_SPD, duck_escaped SHALL pulse for 1 cycle and the state SHALL move to HIDDEN.
REQ-022 HIDDEN: the block SHALL wait RESPAWN_FRAMES frames and then load the spawn point (x=0, y=Y_MAX, dir_x=+, dir_y=−) and enter FLY.
REQ-023 shot_hit SHALL be ignored in every state other than FLY.
REQ-024 duck_show SHALL be 1 in every state except HIDDEN.
REQ-025 duck_hit SHALL be 1 in HIT and FALL.
REQ-026 duck_flap SHALL toggle every FLAP_DIV frames in FLY and ESCAPE, and SHALL be held at 0 otherwise.
REQ-027 All outputs SHALL be registered, giving a latency of 1 cycle from the triggering edge.

Reset
REQ-028 While rst=1, the block SHALL set: state HIDDEN; all counters 0; duck_x=0; duck_y=Y_MAX; dir_x=+; dir_y=−; duck_show, duck_flap, duck_hit and duck_escaped all 0.
REQ-029 Reset asserted mid-flight SHALL take effect asynchronously with no pending pulse left over. After release, the first respawn SHALL occur after RESPAWN_FRAMES frames.

Configuration
REQ-030 Macro CTL_DUCK_RANDOM_SPAWN_EN defined: a 16-bit LFSR (taps 16,14,13,11, seed 16'hACE1, stepping every clk) SHALL set the spawn x to the LFSR value modulo (X_MAX+1). Spawn dir_x SHALL equal LFSR bit 0, where 1 means +.
REQ-031 Macro CTL_DUCK_RANDOM_SPAWN_EN undefined: no LFSR SHALL exist, and the spawn point SHALL be x=0 with dir_x=+.

Verification
REQ-032 Reset, then 60 new_frame pulses: FLY is entered with duck_show=1, x=0, y=400. After 1 further frame: x=7, y=397.
REQ-033 Force x=595 moving + in FLY, then 1 frame: x=600 and dir_x=−. Next frame: x=593.
REQ-034 shot_hit and new_frame on the same cycle in FLY at (100,200): the position is unchanged and duck_hit=1. After 20 frames the duck falls 5 px/frame until y=400, then duck_show=0.
REQ-035 No shot for 180 FLY frames: ESCAPE is entered, y falls 3 px/frame, duck_escaped pulses exactly 1 cycle, then HIDDEN.
REQ-036 shot_hit in HIDDEN and in FALL: no state change and no output change.
REQ-037 rst pulse mid-FALL, asynchronous (not on a clk edge): all outputs reach their reset values before the next clk edge.
